// File: rtl/peripheral_ram_arbiter_if.sv
// Bus bundle between the CPU/DMA masters, the arbiter and the data RAM.
// The master modport is the requester/RAM side, the slave modport is the arbiter.
interface peripheral_ram_arbiter_if #(
   parameter int AW = 6,
   parameter int DW = 16,
   parameter int CW = 3
);
   logic          cpu_req;
   logic [AW-1:0] cpu_addr;
   logic [1:0]    cpu_we;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt;
   logic          cpu_rvalid;
   logic [DW-1:0] cpu_rdata;

   logic          dma_req;
   logic [AW-1:0] dma_addr;
   logic [1:0]    dma_we;
   logic [DW-1:0] dma_wdata;
   logic          dma_gnt;
   logic          dma_rvalid;
   logic [DW-1:0] dma_rdata;

   logic [AW-1:0] soc_ram_addr;
   logic [DW-1:0] soc_ram_din;
   logic          soc_ram_cen;
   logic [1:0]    soc_ram_wen;
   logic [DW-1:0] soc_ram_dout;

   // starvation counter value, zero when the counter is not built
   logic [CW-1:0] dbg_wait_cnt;

   modport slave (
      input  cpu_req, cpu_addr, cpu_we, cpu_wdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata,
      input  dma_req, dma_addr, dma_we, dma_wdata,
      output dma_gnt, dma_rvalid, dma_rdata,
      output soc_ram_addr, soc_ram_din, soc_ram_cen, soc_ram_wen,
      input  soc_ram_dout,
      output dbg_wait_cnt
   );

   modport master (
      output cpu_req, cpu_addr, cpu_we, cpu_wdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata,
      output dma_req, dma_addr, dma_we, dma_wdata,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  soc_ram_addr, soc_ram_din, soc_ram_cen, soc_ram_wen,
      output soc_ram_dout,
      input  dbg_wait_cnt
   );
endinterface

// File: rtl/peripheral_ram_arbiter.sv
// CPU/DMA arbiter in front of the single-port data RAM; CPU has fixed priority.
// Define PERIPHERAL_RAM_ARB_STARVE_EN to bound the DMA wait with a starvation counter.
module peripheral_ram_arbiter #(
   parameter int AW           = 6,
   parameter int DW           = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    soc_ram_clk,
   input  logic                    soc_ram_rst,
   peripheral_ram_arbiter_if.slave bus
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   // Handshake: a master holds req/addr/we/wdata until the cycle its gnt is high;
   // that cycle the access goes to the RAM and is consumed. A read returns data
   // with rvalid exactly one cycle after its gnt; writes return nothing.

   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_e;

   owner_e owner_q, owner_d;
   logic   rst_q;
   logic   blocked;
   logic   force_dma;
   logic   dma_win;
   logic   cpu_win;

   // grants stay off during reset and the first cycle after it
   always_ff @(posedge soc_ram_clk) begin
      rst_q <= soc_ram_rst;
   end

   assign blocked = soc_ram_rst | rst_q;

`ifdef PERIPHERAL_RAM_ARB_STARVE_EN
   logic [CW-1:0] wait_cnt;

   always_ff @(posedge soc_ram_clk) begin
      if (soc_ram_rst) begin
         wait_cnt <= '0;
      end else if (bus.dma_req && !dma_win) begin
         if (wait_cnt != CW'(STARVE_LIMIT)) wait_cnt <= wait_cnt + 1'b1;
      end else begin
         wait_cnt <= '0;
      end
   end

   assign force_dma        = (wait_cnt == CW'(STARVE_LIMIT));
   assign bus.dbg_wait_cnt = wait_cnt;
`else
   assign force_dma        = 1'b0;
   assign bus.dbg_wait_cnt = {CW{1'b0}};
`endif

   always_comb begin
      dma_win          = !blocked && bus.dma_req && (force_dma || !bus.cpu_req);
      cpu_win          = !blocked && bus.cpu_req && !dma_win;
      bus.soc_ram_cen  = 1'b1;
      bus.soc_ram_wen  = 2'b11;
      bus.soc_ram_addr = {AW{1'b0}};
      bus.soc_ram_din  = {DW{1'b0}};
      owner_d          = OWN_NONE;
      if (dma_win) begin
         bus.soc_ram_cen  = 1'b0;
         bus.soc_ram_wen  = ~bus.dma_we;
         bus.soc_ram_addr = bus.dma_addr;
         bus.soc_ram_din  = bus.dma_wdata;
         if (bus.dma_we == 2'b00) owner_d = OWN_DMA;
      end else if (cpu_win) begin
         bus.soc_ram_cen  = 1'b0;
         bus.soc_ram_wen  = ~bus.cpu_we;
         bus.soc_ram_addr = bus.cpu_addr;
         bus.soc_ram_din  = bus.cpu_wdata;
         if (bus.cpu_we == 2'b00) owner_d = OWN_CPU;
      end
   end

   always_ff @(posedge soc_ram_clk) begin
      if (soc_ram_rst) owner_q <= OWN_NONE;
      else             owner_q <= owner_d;
   end

   assign bus.cpu_gnt = cpu_win;
   assign bus.dma_gnt = dma_win;

   // reset kills a read return that would otherwise land in the reset cycle
   assign bus.cpu_rvalid = (owner_q == OWN_CPU) && !soc_ram_rst;
   assign bus.dma_rvalid = (owner_q == OWN_DMA) && !soc_ram_rst;
   assign bus.cpu_rdata  = bus.soc_ram_dout;
   assign bus.dma_rdata  = bus.soc_ram_dout;
endmodule

// File: tb/tb_peripheral_ram_arbiter.sv
// Bench for peripheral_ram_arbiter: directed scenarios then randomized traffic,
// all checked against a cycle-level reference model and a RAM model.
module tb_peripheral_ram_arbiter;
   localparam int AW           = 6;
   localparam int DW           = 16;
   localparam int STARVE_LIMIT = 4;
   localparam int CW           = $clog2(STARVE_LIMIT + 1);
   localparam int DEPTH        = 1 << AW;
`ifdef PERIPHERAL_RAM_ARB_STARVE_EN
   localparam bit STARVE_EN = 1'b1;
`else
   localparam bit STARVE_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   peripheral_ram_arbiter_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

   peripheral_ram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .soc_ram_clk (clk),
      .soc_ram_rst (rst),
      .bus         (bus)
   );

   // ---------------- RAM responder ----------------
   logic [DW-1:0] ram_mem [DEPTH];
   logic [DW-1:0] ram_dout = '0;

   always @(posedge clk) begin
      if (!bus.soc_ram_cen) begin
         if (!bus.soc_ram_wen[0]) ram_mem[bus.soc_ram_addr][7:0]  <= bus.soc_ram_din[7:0];
         if (!bus.soc_ram_wen[1]) ram_mem[bus.soc_ram_addr][15:8] <= bus.soc_ram_din[15:8];
         if (&bus.soc_ram_wen)    ram_dout <= ram_mem[bus.soc_ram_addr];
      end
   end
   assign bus.soc_ram_dout = ram_dout;

   // ---------------- scoreboard / reference model ----------------
   int            vectors     = 0;
   int            miscompares = 0;
   logic [DW-1:0] model_mem [DEPTH];
   logic [DW-1:0] exp_q [$];
   int            waited     = 0;  // consecutive cycles the DMA has been kept waiting
   bit            last_rst   = 1'b1;
   int            pend_owner = 0;  // 0 none, 1 cpu, 2 dma: read return due this cycle

   // DUT observations from the latest checked cycle
   bit            obs_cpu_gnt, obs_dma_gnt, obs_cpu_rvalid, obs_dma_rvalid, obs_cen;
   logic [1:0]    obs_wen;
   logic [DW-1:0] obs_cpu_rdata, obs_dma_rdata;
   int            obs_wait;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_cycle();
      bit            blocked, force_dma, dma_win, cpu_win, exp_cv, exp_dv;
      logic          e_cen;
      logic [1:0]    e_wen, w_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_din, d;
      obs_cpu_gnt    = bus.cpu_gnt;
      obs_dma_gnt    = bus.dma_gnt;
      obs_cpu_rvalid = bus.cpu_rvalid;
      obs_dma_rvalid = bus.dma_rvalid;
      obs_cen        = bus.soc_ram_cen;
      obs_wen        = bus.soc_ram_wen;
      obs_cpu_rdata  = bus.cpu_rdata;
      obs_dma_rdata  = bus.dma_rdata;
      obs_wait       = int'(bus.dbg_wait_cnt);

      blocked   = rst || last_rst;
      force_dma = STARVE_EN && (waited >= STARVE_LIMIT);
      dma_win   = !blocked && bus.dma_req && (force_dma || !bus.cpu_req);
      cpu_win   = !blocked && bus.cpu_req && !dma_win;

      e_cen = 1'b1; e_wen = 2'b11; e_addr = '0; e_din = '0; w_we = 2'b00;
      if (dma_win) begin
         e_cen = 1'b0; w_we = bus.dma_we; e_addr = bus.dma_addr; e_din = bus.dma_wdata;
      end else if (cpu_win) begin
         e_cen = 1'b0; w_we = bus.cpu_we; e_addr = bus.cpu_addr; e_din = bus.cpu_wdata;
      end
      if (!e_cen) e_wen = ~w_we;

      check("cpu_gnt",  32'(bus.cpu_gnt),      32'(cpu_win));
      check("dma_gnt",  32'(bus.dma_gnt),      32'(dma_win));
      check("ram_cen",  32'(bus.soc_ram_cen),  32'(e_cen));
      check("ram_wen",  32'(bus.soc_ram_wen),  32'(e_wen));
      check("ram_addr", 32'(bus.soc_ram_addr), 32'(e_addr));
      check("ram_din",  32'(bus.soc_ram_din),  32'(e_din));
      check("wait_cnt", 32'(bus.dbg_wait_cnt), STARVE_EN ? 32'(waited) : 32'd0);

      exp_cv = (pend_owner == 1) && !rst;
      exp_dv = (pend_owner == 2) && !rst;
      check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(exp_cv));
      check("dma_rvalid", 32'(bus.dma_rvalid), 32'(exp_dv));
      if (pend_owner != 0 && exp_q.size() > 0) begin
         d = exp_q.pop_front();
         if (exp_cv) check("cpu_rdata", 32'(bus.cpu_rdata), 32'(d));
         if (exp_dv) check("dma_rdata", 32'(bus.dma_rdata), 32'(d));
      end
      pend_owner = 0;

      // advance the model across the coming clock edge
      if (rst) begin
         waited = 0;
      end else begin
         if (dma_win || cpu_win) begin
            if (w_we == 2'b00) begin
               exp_q.push_back(model_mem[e_addr]);
               pend_owner = dma_win ? 2 : 1;
            end else begin
               if (w_we[0]) model_mem[e_addr][7:0]  = e_din[7:0];
               if (w_we[1]) model_mem[e_addr][15:8] = e_din[15:8];
            end
         end
         if (bus.dma_req && !dma_win) waited = (waited < STARVE_LIMIT) ? waited + 1 : STARVE_LIMIT;
         else                         waited = 0;
      end
      last_rst = rst;
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cpu(input logic r, input logic [AW-1:0] a, input logic [1:0] we, input logic [DW-1:0] d);
      bus.cpu_req = r; bus.cpu_addr = a; bus.cpu_we = we; bus.cpu_wdata = d;
   endtask

   task automatic set_dma(input logic r, input logic [AW-1:0] a, input logic [1:0] we, input logic [DW-1:0] d);
      bus.dma_req = r; bus.dma_addr = a; bus.dma_we = we; bus.dma_wdata = d;
   endtask

   task automatic cpu_access(input logic [AW-1:0] a, input logic [1:0] we, input logic [DW-1:0] d);
      bit got = 1'b0;
      set_cpu(1'b1, a, we, d);
      for (int i = 0; i < 20 && !got; i++) begin
         cycle();
         got = obs_cpu_gnt;
      end
      check("cpu_access_gnt", 32'(got), 32'd1);
      bus.cpu_req = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cg, dg, peak, dma_idx, cpu_at, cpu_after;
      bit done;
      for (int i = 0; i < DEPTH; i++) begin
         ram_mem[i]   = '0;
         model_mem[i] = '0;
      end
      set_cpu(1'b0, '0, 2'b00, '0);
      set_dma(1'b0, '0, 2'b00, '0);
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      cycle();

      // write then read back
      cpu_access(6'd5, 2'b11, 16'hA55A);
      cpu_access(6'd5, 2'b00, 16'h0000);
      check("tp_read_wen", 32'(obs_wen), 32'h3);
      cycle();
      check("tp_read_rvalid", 32'(obs_cpu_rvalid), 32'd1);
      check("tp_read_data", 32'(obs_cpu_rdata), 32'hA55A);
      check("tp_read_dma_rvalid", 32'(obs_dma_rvalid), 32'd0);

      // upper-byte write over zero
      cpu_access(6'd3, 2'b10, 16'h12FF);
      check("tp_byte_wen", 32'(obs_wen), 32'h1);
      cpu_access(6'd3, 2'b00, 16'h0000);
      cycle();
      check("tp_byte_data", 32'(obs_cpu_rdata), 32'h1200);

      // simultaneous single requests
      set_cpu(1'b1, 6'd10, 2'b11, 16'hBEEF);
      set_dma(1'b1, 6'd11, 2'b11, 16'hCAFE);
      cg = -1; dg = -1; peak = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         if (obs_wait > peak) peak = obs_wait;
         if (obs_cpu_gnt && cg < 0) begin cg = i; bus.cpu_req = 1'b0; end
         if (obs_dma_gnt && dg < 0) begin dg = i; bus.dma_req = 1'b0; end
      end
      check("tp_simul_cpu_cycle", 32'(cg), 32'd0);
      check("tp_simul_dma_cycle", 32'(dg), 32'd1);
      check("tp_simul_wait_peak", 32'(peak), STARVE_EN ? 32'd1 : 32'd0);

      // starvation under continuous CPU traffic
      set_cpu(1'b1, 6'd7, 2'b00, '0);
      set_dma(1'b1, 6'd1, 2'b00, '0);
      dma_idx = -1; cpu_at = -1; cpu_after = -1;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (obs_dma_gnt && dma_idx < 0) begin
            dma_idx = i; cpu_at = int'(obs_cpu_gnt); bus.dma_req = 1'b0;
         end else if (dma_idx >= 0 && i == dma_idx + 1) begin
            cpu_after = int'(obs_cpu_gnt);
         end
      end
      check("tp_starve_dma_cycle", 32'(dma_idx), STARVE_EN ? 32'(STARVE_LIMIT) : 32'hFFFF_FFFF);
      check("tp_starve_cpu_stall", 32'(cpu_at), STARVE_EN ? 32'd0 : 32'hFFFF_FFFF);
      check("tp_starve_cpu_resume", 32'(cpu_after), STARVE_EN ? 32'd1 : 32'hFFFF_FFFF);
      bus.cpu_req = 1'b0;
      done = !bus.dma_req;
      for (int i = 0; i < 5 && !done; i++) begin
         cycle();
         if (obs_dma_gnt) begin done = 1'b1; bus.dma_req = 1'b0; end
      end
      check("tp_starve_dma_served", 32'(done), 32'd1);
      cycle();
      cycle();

      // back-to-back reads from different masters
      cpu_access(6'd1, 2'b11, 16'h0101);
      cpu_access(6'd2, 2'b11, 16'h0202);
      set_dma(1'b1, 6'd1, 2'b00, '0);
      cycle();
      check("tp_b2b_dma_gnt", 32'(obs_dma_gnt), 32'd1);
      bus.dma_req = 1'b0;
      set_cpu(1'b1, 6'd2, 2'b00, '0);
      cycle();
      check("tp_b2b_dma_rvalid", 32'(obs_dma_rvalid), 32'd1);
      check("tp_b2b_cpu_gnt", 32'(obs_cpu_gnt), 32'd1);
      check("tp_b2b_dma_data", 32'(obs_dma_rdata), 32'h0101);
      bus.cpu_req = 1'b0;
      cycle();
      check("tp_b2b_cpu_rvalid", 32'(obs_cpu_rvalid), 32'd1);
      check("tp_b2b_cpu_data", 32'(obs_cpu_rdata), 32'h0202);

      // reset arriving right after a granted read
      set_cpu(1'b1, 6'd5, 2'b00, '0);
      cycle();
      check("tp_rst_read_gnt", 32'(obs_cpu_gnt), 32'd1);
      bus.cpu_req = 1'b0;
      set_dma(1'b1, 6'd20, 2'b11, 16'h5A5A);
      rst = 1'b1;
      cycle();
      check("tp_rst_cpu_rvalid", 32'(obs_cpu_rvalid), 32'd0);
      check("tp_rst_cen", 32'(obs_cen), 32'd1);
      check("tp_rst_dma_gnt", 32'(obs_dma_gnt), 32'd0);
      rst = 1'b0;
      cycle();
      check("tp_rst_after_gnt", 32'(obs_dma_gnt), 32'd0);
      cycle();
      check("tp_rst_release_gnt", 32'(obs_dma_gnt), 32'd1);
      bus.dma_req = 1'b0;
      cycle();

      // randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         cycle();
         if (obs_cpu_gnt) bus.cpu_req = 1'b0;
         if (obs_dma_gnt) bus.dma_req = 1'b0;
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 199) == 0) rst = 1'b1;
         if (!bus.cpu_req && $urandom_range(0, 99) < 55)
            set_cpu(1'b1, AW'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), DW'($urandom));
         if (!bus.dma_req && $urandom_range(0, 99) < 45)
            set_dma(1'b1, AW'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), DW'($urandom));
      end
      rst = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         cycle();
         if (obs_cpu_gnt) bus.cpu_req = 1'b0;
         if (obs_dma_gnt) bus.dma_req = 1'b0;
         done = !bus.cpu_req && !bus.dma_req;
      end
      check("drain_done", 32'(done), 32'd1);
      cycle();
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/peripheral_ram_arbiter.md
# peripheral_ram_arbiter

Two-master arbiter in front of the MSP430 single-port data RAM. It merges the CPU data port and the DMA port into one `soc_ram_*` request stream: active-low chip enable, active-low byte write enables, one-cycle synchronous read. It returns read data to whichever master issued the read. The CPU has fixed priority, and a starvation counter bounds the DMA wait.

## Interface
- `AW`, 6, RAM word address width
- `DW`, 16, RAM data width (two bytes)
- `STARVE_LIMIT`, 4, consecutive stalled DMA cycles before the DMA is forced through (≥1)

Ports:
- `soc_ram_clk`  in  1  RAM clock; all state on rising edge
- `soc_ram_rst`  in  1  reset; one clock, synchronous, active-high
- `cpu_req`  in  1  CPU access request
- `cpu_addr`  in  AW  CPU word address
- `cpu_we`  in  2  CPU byte write enables, active-high; 2'b00 = read
- `cpu_wdata`  in  DW  CPU write data
- `cpu_gnt`  out  1  CPU request accepted this cycle
- `cpu_rvalid`  out  1  CPU read data valid
- `cpu_rdata`  out  DW  CPU read data
- `dma_req`, `dma_addr`, `dma_we`, `dma_wdata`, `dma_gnt`, `dma_rvalid`, `dma_rdata`: same widths and meaning for the DMA
- `soc_ram_addr`  out  AW  RAM address
- `soc_ram_din`  out  DW  RAM write data
- `soc_ram_cen`  out  1  RAM chip enable, active-low
- `soc_ram_wen`  out  2  RAM byte write enables, active-low
- `soc_ram_dout`  in  DW  RAM read data, valid one cycle after a read access

## Operation
- **Arbitration** is combinational each cycle. Winner = DMA if `dma_req && (force_dma || !cpu_req)`; else CPU if `cpu_req`; else idle.
- **Grant:** `*_gnt` is 1 only for the winner. A request is consumed in the cycle its gnt is high. Masters hold req/addr/we/wdata stable until granted.
- **RAM drive, winner present:** `soc_ram_cen`=0, `soc_ram_addr`/`soc_ram_din` = winner's values, `soc_ram_wen` = `~winner_we`.
- **RAM drive, idle:** `soc_ram_cen`=1, `soc_ram_wen`=2'b11, `soc_ram_addr`=0, `soc_ram_din`=0.
- **Read tracking:** a granted read (`we`==2'b00) sets a registered owner tag. Next cycle the owner's `*_rvalid`=1. `cpu_rdata` and `dma_rdata` both mirror `soc_ram_dout` unconditionally. Masters qualify with rvalid.
- **Writes** produce no rvalid. Partial writes (2'b01 or 2'b10) pass through as single-byte `soc_ram_wen`.
- **Starvation counter `wait_cnt`**, width $clog2(STARVE_LIMIT+1):
  - increments while `dma_req && !dma_gnt`, saturating at STARVE_LIMIT;
  - clears when `dma_gnt` or `!dma_req`.
- **Forcing the DMA:** `force_dma` = (`wait_cnt`==STARVE_LIMIT). The DMA wins exactly one access; the CPU stalls that cycle (`cpu_gnt`=0).
- **Back-to-back accesses:** one access per cycle, no bubbles. A read followed by any access next cycle is legal; the rvalid of the first overlaps the grant of the second.

## Timing
- **Reset values (during reset and the cycle after):**
  - `cpu_gnt`=`dma_gnt`=0, `cpu_rvalid`=`dma_rvalid`=0
  - `soc_ram_cen`=1, `soc_ram_wen`=2'b11, `soc_ram_addr`=0, `soc_ram_din`=0
  - `wait_cnt`=0, owner tag cleared
- Grants are suppressed while `soc_ram_rst`=1.
- **Reset mid-operation:** a read granted in the cycle before reset asserts produces no rvalid.
- **Grant latency:** 0 cycles when uncontended. Max DMA wait under continuous CPU traffic is STARVE_LIMIT cycles, granted in cycle STARVE_LIMIT+1.
- **Read latency:** rvalid exactly 1 cycle after gnt.
- **Simultaneous requests, `wait_cnt`<STARVE_LIMIT:** CPU wins and `wait_cnt` increments.
- **Simultaneous requests, `wait_cnt`==STARVE_LIMIT:** DMA wins and `wait_cnt` clears next edge.

## Configuration
- `PERIPHERAL_RAM_ARB_STARVE_EN` defined: starvation counter and `force_dma` implemented as above.
- Not defined: strict CPU priority. `force_dma` is tied 0 and `wait_cnt` is absent; the DMA is granted only when `cpu_req`=0. `STARVE_LIMIT` is ignored.

## Test plan
- **CPU read after reset:** reset 2 cycles, then CPU write addr 5, we 2'b11, data 16'hA55A. Next cycle CPU read addr 5 → `soc_ram_cen`=0, `soc_ram_wen`=2'b11 in the read cycle; `cpu_rvalid`=1 and `cpu_rdata`=16'hA55A one cycle later; `dma_rvalid`=0.
- **Byte write:** CPU write addr 3, we 2'b10, data 16'h12FF over 16'h0000 → `soc_ram_wen`=2'b01; a read of addr 3 returns 16'h1200.
- **Simultaneous requests:** `cpu_req` and `dma_req` both high for one request each → CPU granted cycle 0, DMA granted cycle 1, and `wait_cnt` peaks at 1.
- **Starvation:** continuous `cpu_req` plus `dma_req` held, STARVE_LIMIT=4 → `dma_gnt` in cycle 5, `cpu_gnt`=0 that cycle, CPU granted again cycle 6. With the macro undefined → `dma_gnt` never asserts while `cpu_req`=1.
- **Back-to-back reads:** DMA reads addr 1, then CPU reads addr 2 in the next cycle → `dma_rvalid` and `cpu_gnt` in the same cycle, `cpu_rvalid` the cycle after, each returning its own data.
- **Reset mid-read:** CPU read granted, `soc_ram_rst` asserted the next cycle → `cpu_rvalid`=0, `soc_ram_cen`=1, and all grants 0 until reset is released.
